// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM states and select encodings for the RSA exponent sequencer
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, INIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE} state_t;
  localparam logic SRC_ONE = 1'b0;
  localparam logic SRC_MUL = 1'b1;
  localparam logic MUL_SQR = 1'b0;
  localparam logic MUL_MUL = 1'b1;
endpackage

// File: rtl/rsa_lead_one.sv
// rsa_lead_one: index of the highest set bit plus an all-zero flag
module rsa_lead_one #(
  parameter int WIDTH = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             zero
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = vec[i] ? IW'(i) : idx;
  end
  assign zero = ~|vec;
endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: left-to-right square-and-multiply sequencer for C = M^E mod N
// RSA_EXP_SKIP_LEADING_EN: begin the scan at the highest set exponent bit
import rsa_pkg::*;
module rsa_exp_ctrl #(
  parameter int WIDTH = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] exp_i,
  input  logic             mul_done,
  output logic             mul_start,
  output logic             mul_sel,
  output logic             reg_ena,
  output logic             reg_clear_n,
  output logic             reg_load,
  output logic             src_sel,
  output logic [IW-1:0]    bit_idx,
  output logic             busy,
  output logic             done
);
  state_t state, state_nx;
  logic [WIDTH-1:0] exp_r;
  logic [IW-1:0] start_idx;
  logic skip_init, accept, load;
`ifdef RSA_EXP_SKIP_LEADING_EN
  logic lead_zero, zero_r;
  rsa_lead_one #(.WIDTH(WIDTH)) u_lead (.vec(exp_i), .idx(start_idx), .zero(lead_zero));
  // An all-zero exponent needs no squarings at all, so INIT jumps straight to DONE
  always_ff @(posedge clk) zero_r <= rst ? 1'b0 : accept ? lead_zero : zero_r;
  assign skip_init = zero_r;
`else
  assign start_idx = IW'(WIDTH - 1);
  assign skip_init = 1'b0;
`endif
  assign accept = state == IDLE && start && !abort;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r   <= '0;
      bit_idx <= IW'(WIDTH - 1);
    end else if (accept) begin
      exp_r   <= exp_i;
      bit_idx <= start_idx;
    end else if (state == NEXT && !abort && bit_idx != '0) begin
      bit_idx <= bit_idx - 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? INIT : IDLE;
      INIT:     state_nx = skip_init ? DONE : SQ_REQ;
      SQ_REQ:   state_nx = SQ_WAIT;
      SQ_WAIT:  state_nx = !mul_done ? SQ_WAIT : exp_r[bit_idx] ? MUL_REQ : NEXT;
      MUL_REQ:  state_nx = MUL_WAIT;
      MUL_WAIT: state_nx = mul_done ? NEXT : MUL_WAIT;
      NEXT:     state_nx = (bit_idx == '0) ? DONE : SQ_REQ;
      default:  state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  // Abort overrides both the multiplier request and any coincident result load
  always_comb begin
    load        = !abort && (state == INIT || ((state == SQ_WAIT || state == MUL_WAIT) && mul_done));
    mul_start   = !abort && (state == SQ_REQ || state == MUL_REQ);
    mul_sel     = (state == MUL_REQ || state == MUL_WAIT) ? MUL_MUL : MUL_SQR;
    src_sel     = (state == SQ_WAIT || state == MUL_WAIT) ? SRC_MUL : SRC_ONE;
    reg_load    = load;
    reg_ena     = load || abort;
    reg_clear_n = !abort;
    busy        = state != IDLE;
    done        = state == DONE;
  end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: randomized check of the exponent sequencer against a modexp reference
module tb_rsa_exp_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, mul_done = 1'b0;
  logic [W-1:0] exp_i = '0;
  logic mul_start, mul_sel, reg_ena, reg_clear_n, reg_load, src_sel, busy, done;
  logic [1:0] bit_idx;
  int pass_n = 0, tot_n = 0;
  int m_val, n_val;

  rsa_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_i(exp_i), .mul_done(mul_done),
    .mul_start(mul_start), .mul_sel(mul_sel), .reg_ena(reg_ena), .reg_clear_n(reg_clear_n),
    .reg_load(reg_load), .src_sel(src_sel), .bit_idx(bit_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drives one exponentiation with a responding multiplier that really computes mod N
  task automatic run_op(input logic [W-1:0] e, input int lat, input bit disturb,
                        output logic [15:0] sels, output int n_st, output int n_one,
                        output int n_mul, output int dcyc, output int res);
    int due, c_val, prod;
    sels = '0; n_st = 0; n_one = 0; n_mul = 0; dcyc = -1; due = -1; c_val = 0; prod = 0;
    @(negedge clk);
    start = 1'b1; exp_i = e;
    @(posedge clk);
    for (int c = 1; c < 400 && dcyc < 0; c++) begin
      @(negedge clk);
      start = disturb;
      mul_done = (c == due) || (disturb && c == 2);
      #1;
      if (mul_start) begin
        if (n_st < 16) sels[n_st] = mul_sel;
        n_st++;
        prod = mul_sel ? (c_val * m_val) % n_val : (c_val * c_val) % n_val;
        due = c + lat;
      end
      if (reg_load && reg_ena) begin
        if (src_sel) begin n_mul++; c_val = prod; end
        else begin n_one++; c_val = 1; end
      end
      if (done) dcyc = c;
    end
    start = 1'b0; mul_done = 1'b0;
    res = c_val;
  endtask

  task automatic test_exp(input logic [W-1:0] e, input int lat, input bit disturb);
    logic [15:0] o_sel, x_sel;
    int o_st, o_one, o_mul, o_dc, o_res, x_n, x_ones, x_dc, x_res, top;
    n_val = 2 * $urandom_range(5, 120) + 1;
    m_val = $urandom_range(2, n_val - 1);
    x_sel = '0; x_n = 0; x_ones = 0; top = W - 1;
`ifdef RSA_EXP_SKIP_LEADING_EN
    top = -1;
    for (int i = 0; i < W; i++) if (e[i]) top = i;
`endif
    for (int i = top; i >= 0; i--) begin
      x_sel[x_n] = 1'b0; x_n++;
      if (e[i]) begin x_sel[x_n] = 1'b1; x_n++; x_ones++; end
    end
    x_dc = 2 + (top + 1) * (lat + 2) + x_ones * (lat + 1);
    x_res = 1;
    for (int k = 0; k < int'(e); k++) x_res = (x_res * m_val) % n_val;
    run_op(e, lat, disturb, o_sel, o_st, o_one, o_mul, o_dc, o_res);
    tot_n++;
    if (o_st !== x_n || o_sel !== x_sel)
      $display("FAIL mul_seq e=%b L=%0d: got %0d starts sel=%b, want %0d starts sel=%b", e, lat, o_st, o_sel, x_n, x_sel);
    else pass_n++;
    tot_n++;
    if (o_one !== 1 || o_mul !== x_n)
      $display("FAIL loads e=%b: got one=%0d mul=%0d, want one=1 mul=%0d", e, o_one, o_mul, x_n);
    else pass_n++;
    tot_n++;
    if (o_dc !== x_dc) $display("FAIL done_cycle e=%b L=%0d: got %0d, want %0d", e, lat, o_dc, x_dc);
    else pass_n++;
    tot_n++;
    if (o_res !== x_res) $display("FAIL result e=%b M=%0d N=%0d: got %0d, want %0d", e, m_val, n_val, o_res, x_res);
    else pass_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tot_n++;
    if ({mul_start, mul_sel, reg_ena, reg_clear_n, reg_load, src_sel, busy, done} !== 8'b0001_0000 || bit_idx !== 2'd3)
      $display("FAIL reset_outputs: got %b idx=%0d, want 00010000 idx=3",
               {mul_start, mul_sel, reg_ena, reg_clear_n, reg_load, src_sel, busy, done}, bit_idx);
    else pass_n++;
  endtask

  task automatic test_fixed();
    test_exp(4'b1011, 1, 1'b0);
    test_exp(4'b0011, 1, 1'b0);
    test_exp(4'b0000, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_exp(4'b1011, 1, 1'b1);
    test_exp(4'b0110, 2, 1'b0);
  endtask

  task automatic test_abort();
    int due, quiet;
    bit hit;
    due = -1; hit = 1'b0; quiet = 1;
    @(negedge clk);
    start = 1'b1; exp_i = 4'b1011;
    @(posedge clk);
    for (int c = 1; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == due && mul_sel) begin
        mul_done = 1'b1; abort = 1'b1;
        #1;
        hit = 1'b1;
        tot_n++;
        if ({reg_clear_n, reg_ena, reg_load, mul_start} !== 4'b0100)
          $display("FAIL abort_outputs: got clr_n/ena/load/start=%b, want 0100", {reg_clear_n, reg_ena, reg_load, mul_start});
        else pass_n++;
      end else begin
        mul_done = (c == due);
        #1;
        if (mul_start) due = c + 2;
      end
    end
    tot_n++;
    if (!hit) $display("FAIL abort_reach: got no MUL_WAIT completion, want one");
    else pass_n++;
    @(negedge clk);
    abort = 1'b0; mul_done = 1'b0;
    #1;
    tot_n++;
    if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b, want 0", busy);
    else pass_n++;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (done || busy) quiet = 0;
    end
    tot_n++;
    if (quiet !== 1) $display("FAIL abort_no_done: got activity after abort, want none");
    else pass_n++;
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    #1;
    tot_n++;
    if ({reg_clear_n, reg_ena} !== 2'b01) $display("FAIL idle_abort_clear: got clr_n/ena=%b, want 01", {reg_clear_n, reg_ena});
    else pass_n++;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #1;
    tot_n++;
    if (busy !== 1'b0) $display("FAIL idle_abort_start: got busy=%b, want 0", busy);
    else pass_n++;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; exp_i = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tot_n++;
    if (!(busy && !mul_start && !mul_sel)) $display("FAIL rst_mid_state: got busy=%b start=%b sel=%b, want 1 0 0", busy, mul_start, mul_sel);
    else pass_n++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tot_n++;
    if ({mul_start, mul_sel, reg_ena, reg_clear_n, reg_load, src_sel, busy, done} !== 8'b0001_0000 || bit_idx !== 2'd3)
      $display("FAIL rst_mid_outputs: got %b idx=%0d, want 00010000 idx=3",
               {mul_start, mul_sel, reg_ena, reg_clear_n, reg_load, src_sel, busy, done}, bit_idx);
    else pass_n++;
    test_exp(4'b1111, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) test_exp(W'($urandom_range(0, 15)), $urandom_range(1, 4), 1'b0);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
Sequencer for RSA modular exponentiation C = M^E mod N using left-to-right square-and-multiply. It scans a captured exponent MSB-first and issues square and multiply requests to the shared modular multiplier via a start/done handshake. It drives the enable, active-low clear and load controls, plus the source select, of the ciphertext result register. It sits between the top-level command interface and the multiplier/result-register datapath.

Parameters:
WIDTH, 4, exponent width in bits; also sets the bit_idx width, $clog2(WIDTH), minimum 1.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, synchronous, active-high
start  input  1  begin exponentiation; sampled only in IDLE
abort  input  1  cancel operation and clear result register
exp_i  input  WIDTH  exponent E; captured when start is accepted
mul_done  input  1  multiplier completion pulse
mul_start  output  1  one-cycle request pulse to multiplier
mul_sel  output  1  0 = square (C*C), 1 = multiply (C*M)
reg_ena  output  1  result register enable
reg_clear_n  output  1  result register clear, active-low
reg_load  output  1  result register load
src_sel  output  1  result register input select: 0 = constant one, 1 = multiplier result
bit_idx  output  $clog2(WIDTH)  current exponent bit
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, bit_idx=WIDTH-1, exponent register=0. All outputs 0, except reg_clear_n=1.
- Outputs are Moore-decoded from state, except the load on mul_done and the clear on abort, which are asserted in the same cycle as the input.
- IDLE: start=1 -> capture exp_i, set bit_idx=WIDTH-1, go to INIT.
- INIT: reg_ena=1, reg_load=1, src_sel=0 (C := 1) -> SQ_REQ.
- SQ_REQ: mul_start=1, mul_sel=0 -> SQ_WAIT.
- SQ_WAIT: mul_sel=0 held. On mul_done: reg_ena=1, reg_load=1, src_sel=1. Then go to MUL_REQ if exp[bit_idx]=1, else NEXT.
- MUL_REQ: mul_start=1, mul_sel=1 -> MUL_WAIT.
- MUL_WAIT: mul_sel=1 held. On mul_done: load as in SQ_WAIT, then go to NEXT.
- NEXT: bit_idx==0 -> DONE; otherwise bit_idx-1 -> SQ_REQ.
- DONE: done=1 for one cycle -> IDLE.
- Latency (start in cycle 0, multiplier asserts mul_done L>=1 cycles after mul_start): done in cycle 2 + WIDTH*(L+2) + ones(E)*(L+1).
- start while busy: ignored. mul_done in any non-WAIT state: ignored.
- abort in any non-IDLE state:
  - reg_ena=1, reg_clear_n=0 that cycle; mul_start=0.
  - Next state IDLE; no done pulse.
  - abort wins over a simultaneous mul_done.
- abort in IDLE: the clear is still issued; start in the same cycle is ignored.
- rst mid-operation: returns to IDLE next edge; the result register is handled by its own reset.
- Exponent E=0: result stays 1 (only squares of 1 are performed).

Optional Feature:
RSA_EXP_SKIP_LEADING_EN
- Defined: on start, bit_idx is loaded with the index of the highest set bit of exp_i, so leading-zero squarings are skipped.
  - E=0: INIT -> DONE directly. Result is 1, and done arrives in cycle 2.
  - Latency: 2 + (msb+1)*(L+2) + ones(E)*(L+1), where msb is the index of the highest set bit.
- Undefined: always WIDTH iterations, as in Behaviour.

Decomposition:
- Shared package rsa_pkg:
  - state enum (IDLE, INIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE)
  - src_sel encodings SRC_ONE=0, SRC_MUL=1
  - mul_sel encodings MUL_SQR=0, MUL_MUL=1
- Sub-module rsa_lead_one: combinational priority encoder returning the highest set index and an all-zero flag. Instantiated only under RSA_EXP_SKIP_LEADING_EN.

Test Plan:
- Multiplier model with L=1; start with exp_i=4'b1011 -> mul_sel sequence 0,1,0,0,1,0,1 with 7 mul_start pulses and 7 src_sel=1 loads; done in cycle 20.
- exp_i=4'b0011, L=1, feature off -> 4 squares + 2 multiplies, done in cycle 18. Feature on -> 2 squares + 2 multiplies, done in cycle 12.
- exp_i=0 -> one INIT load with src_sel=0 and no multiplies. Done in cycle 2 with the feature on; done in cycle 14 with 4 squares with it off.
- abort during MUL_WAIT, coincident with mul_done -> reg_clear_n=0 and reg_ena=1 that cycle, no reg_load, IDLE next cycle, no done pulse.
- start re-pulsed while busy and mul_done injected during SQ_REQ -> both ignored; the sequence and cycle count are unchanged.
- rst asserted mid-SQ_WAIT -> IDLE and reset output values next edge; a following start runs normally.
